// File: rtl/params_pkg.sv
// params_pkg -- shared memory-stage types and constants.
//   mem_op_t       : memory-stage operation carried down the pipeline
//   axil_state_t   : AXI-Lite master controller states
//   axil_req_t     : latched address/data of the access in flight
//   AXIL_RESP_OKAY : AXI-Lite OKAY response code
//   AXIL_TIMEOUT_DEFAULT : default per-transaction cycle budget
package params_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LW   = 2'd1,
    MEM_SW   = 2'd2,
    MEM_LBU  = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    AXIL_IDLE    = 3'd0,
    AXIL_WR_REQ  = 3'd1,
    AXIL_WR_RESP = 3'd2,
    AXIL_RD_REQ  = 3'd3,
    AXIL_RD_RESP = 3'd4,
    AXIL_DONE    = 3'd5
  } axil_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } axil_req_t;

  localparam logic [1:0] AXIL_RESP_OKAY       = 2'b00;
  localparam int         AXIL_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/axil_master_ctrl_if.sv
// axil_master_ctrl_if -- AXI-Lite (32-bit) bus bundle.
//   master modport : drives AW/W/AR valid+payload, BREADY, RREADY
//   slave  modport : drives AW/W/AR ready, B/R valid+response+data
interface axil_master_ctrl_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_master_ctrl.sv
// axil_master_ctrl -- memory-stage AXI-Lite master for routed LW/SW accesses.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   axil_en     : routed AXI-Lite access request (from mem_router)
//   mem_op      : memory-stage op; only MEM_LW / MEM_SW start an access
//   axil_addr   : routed address
//   store_data  : SW data
//   stall       : hold the pipeline while an access is pending
//   load_data   : LW result (held until the next access completes)
//   done        : one-cycle completion pulse
//   axil_err    : SLVERR/DECERR or timeout on the completed access
//   axil        : AXI-Lite master bus
module axil_master_ctrl
  import params_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = AXIL_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axil_en,
  input  mem_op_t              mem_op,
  input  logic [31:0]          axil_addr,
  input  logic [31:0]          store_data,
  output logic                 stall,
  output logic [31:0]          load_data,
  output logic                 done,
  output logic                 axil_err,
  axil_master_ctrl_if.master   axil
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  axil_state_t      state, state_n;
  axil_req_t        req_q, req_n;
  logic             aw_done, aw_done_n, w_done, w_done_n;
  logic [31:0]      load_q, load_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept_sw, accept_lw, busy, timeout, aw_hs, w_hs;

  assign accept_sw = axil_en && (mem_op == MEM_SW);
  assign accept_lw = axil_en && (mem_op == MEM_LW);
  assign busy      = state inside {AXIL_WR_REQ, AXIL_WR_RESP, AXIL_RD_REQ, AXIL_RD_RESP};
  assign timeout   = (cnt == CNT_LAST);

  // Bus outputs are decoded from state plus the per-channel done flags, so
  // a VALID can only fall on its own handshake, on completion or on timeout.
  assign axil.awvalid = (state == AXIL_WR_REQ) && !aw_done;
  assign axil.wvalid  = (state == AXIL_WR_REQ) && !w_done;
  assign axil.awaddr  = req_q.addr;
  assign axil.wdata   = req_q.data;
  assign axil.wstrb   = 4'hF;
  assign axil.bready  = (state == AXIL_WR_RESP);
  assign axil.arvalid = (state == AXIL_RD_REQ);
  assign axil.araddr  = req_q.addr;
  assign axil.rready  = (state == AXIL_RD_RESP);

  assign aw_hs = axil.awvalid && axil.awready;
  assign w_hs  = axil.wvalid && axil.wready;

  // Stall must rise in the very cycle the request is presented.
  assign stall     = ((state == AXIL_IDLE) && (accept_sw || accept_lw)) || busy;
  assign done      = (state == AXIL_DONE);
  assign load_data = load_q;
  assign axil_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= AXIL_IDLE;
      req_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      load_q  <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      req_q   <= req_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      load_q  <= load_n;
      err_q   <= err_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    req_n     = req_q;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    load_n    = load_q;
    err_n     = err_q;
    cnt_n     = cnt;

    // Saturating cycle counter; it only matters while the bus is busy.
    if (busy && !(&cnt)) cnt_n = cnt + CNT_W'(1);

    case (state)
      AXIL_IDLE: begin
        if (accept_sw) begin
          req_n.addr = axil_addr;
          req_n.data = store_data;
          aw_done_n  = 1'b0;
          w_done_n   = 1'b0;
          cnt_n      = '0;
          state_n    = AXIL_WR_REQ;
        end else if (accept_lw) begin
          req_n.addr = axil_addr;
          cnt_n      = '0;
          state_n    = AXIL_RD_REQ;
        end
      end
      AXIL_WR_REQ: begin
        aw_done_n = aw_done || aw_hs;
        w_done_n  = w_done || w_hs;
        if (timeout) begin
          err_n   = 1'b1;
          load_n  = '0;
          state_n = AXIL_DONE;
        end else if (aw_done_n && w_done_n) begin
          state_n = AXIL_WR_RESP;
        end
      end
      AXIL_WR_RESP: begin
        // A response arriving in the last allowed cycle still counts.
        if (axil.bvalid) begin
          err_n   = (axil.bresp != AXIL_RESP_OKAY);
          state_n = AXIL_DONE;
        end else if (timeout) begin
          err_n   = 1'b1;
          load_n  = '0;
          state_n = AXIL_DONE;
        end
      end
      AXIL_RD_REQ: begin
        if (timeout) begin
          err_n   = 1'b1;
          load_n  = '0;
          state_n = AXIL_DONE;
        end else if (axil.arready) begin
          state_n = AXIL_RD_RESP;
        end
      end
      AXIL_RD_RESP: begin
        if (axil.rvalid) begin
          load_n  = axil.rdata;
          err_n   = (axil.rresp != AXIL_RESP_OKAY);
          state_n = AXIL_DONE;
        end else if (timeout) begin
          err_n   = 1'b1;
          load_n  = '0;
          state_n = AXIL_DONE;
        end
      end
      AXIL_DONE: state_n = AXIL_IDLE;
      default:   state_n = AXIL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_master_ctrl.sv
// tb_axil_master_ctrl -- self-checking bench for axil_master_ctrl.
// A configurable-latency AXI-Lite slave answers the DUT; expected latency,
// load data and error flag come from the slave's configured delays and
// responses, not from the controller's internals.
module tb_axil_master_ctrl;
  import params_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axil_en;
  mem_op_t     mem_op;
  logic [31:0] axil_addr, store_data;
  logic        stall, done, axil_err;
  logic [31:0] load_data;

  axil_master_ctrl_if bus();

  axil_master_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axil_en    (axil_en),
    .mem_op     (mem_op),
    .axil_addr  (axil_addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .axil_err   (axil_err),
    .axil       (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // slave configuration
  int          cfg_aw_d, cfg_w_d, cfg_ar_d, cfg_b_d, cfg_r_d;
  bit          cfg_b_never, cfg_r_never;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  // reference model of the architecturally visible result
  logic [31:0] exp_load;
  logic        exp_err;

  // bus monitor: handshake counts and stability violations
  int          n_aw, n_w, n_b, n_ar, n_r, n_stab;
  logic        pend_aw, pend_w, pend_ar;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_r <= 0; n_stab <= 0;
      pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0;
      prev_awaddr <= '0; prev_wdata <= '0; prev_araddr <= '0;
    end else begin
      if (bus.awvalid && bus.awready) n_aw <= n_aw + 1;
      if (bus.wvalid  && bus.wready)  n_w  <= n_w + 1;
      if (bus.bvalid  && bus.bready)  n_b  <= n_b + 1;
      if (bus.arvalid && bus.arready) n_ar <= n_ar + 1;
      if (bus.rvalid  && bus.rready)  n_r  <= n_r + 1;
      n_stab <= n_stab
        + int'(pend_aw && (!bus.awvalid || bus.awaddr !== prev_awaddr))
        + int'(pend_w  && (!bus.wvalid  || bus.wdata  !== prev_wdata))
        + int'(pend_ar && (!bus.arvalid || bus.araddr !== prev_araddr))
        + int'(bus.wvalid && bus.wstrb !== 4'hF);
      pend_aw <= bus.awvalid && !bus.awready;
      pend_w  <= bus.wvalid  && !bus.wready;
      pend_ar <= bus.arvalid && !bus.arready;
      prev_awaddr <= bus.awaddr;
      prev_wdata  <= bus.wdata;
      prev_araddr <= bus.araddr;
    end
  end

  // slave: READY after a programmable number of VALID cycles, responses a
  // programmable number of cycles after they become owed
  initial begin
    int aw_w, w_w, ar_w, b_w, r_w;
    aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.awvalid) begin bus.awready = (aw_w >= cfg_aw_d); aw_w++; end
      else begin bus.awready = 1'b0; aw_w = 0; end
      if (bus.wvalid) begin bus.wready = (w_w >= cfg_w_d); w_w++; end
      else begin bus.wready = 1'b0; w_w = 0; end
      if (bus.arvalid) begin bus.arready = (ar_w >= cfg_ar_d); ar_w++; end
      else begin bus.arready = 1'b0; ar_w = 0; end
      if (n_aw > n_b && n_w > n_b) begin
        bus.bvalid = !cfg_b_never && (b_w >= cfg_b_d); bus.bresp = cfg_bresp; b_w++;
      end else begin bus.bvalid = 1'b0; b_w = 0; end
      if (n_ar > n_r) begin
        bus.rvalid = !cfg_r_never && (r_w >= cfg_r_d);
        bus.rdata = cfg_rdata; bus.rresp = cfg_rresp; r_w++;
      end else begin bus.rvalid = 1'b0; r_w = 0; end
    end
  end

  // per-transaction observation record, index = cycles after acceptance
  bit          h_aw[64], h_w[64], h_ar[64], h_b[64], h_stall[64];
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr, r_load, r_load_after;
  logic [3:0]  cap_wstrb;
  logic        r_err, r_err_after, r_done_after;

  task automatic slave_cfg(input int awd, input int wd, input int ard, input int bd, input int rd);
    cfg_aw_d = awd; cfg_w_d = wd; cfg_ar_d = ard; cfg_b_d = bd; cfg_r_d = rd;
    cfg_b_never = 1'b0; cfg_r_never = 1'b0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
  endtask

  // present one request for a single cycle and follow it to DONE
  task automatic do_txn(input mem_op_t op, input logic [31:0] a, input logic [31:0] d, output int lat);
    lat = -1;
    for (int i = 0; i < 64; i++) begin
      h_aw[i] = 0; h_w[i] = 0; h_ar[i] = 0; h_b[i] = 0; h_stall[i] = 0;
    end
    @(negedge clk);
    axil_en = 1'b1; mem_op = op; axil_addr = a; store_data = d;
    #1;
    h_stall[0] = stall;
    for (int n = 1; n < 64; n++) begin
      @(negedge clk);
      axil_en = 1'b0; mem_op = MEM_NONE;
      #1;
      h_aw[n] = bus.awvalid; h_w[n] = bus.wvalid; h_ar[n] = bus.arvalid;
      h_b[n] = bus.bready; h_stall[n] = stall;
      if (n == 1) begin
        cap_awaddr = bus.awaddr; cap_wdata = bus.wdata;
        cap_wstrb = bus.wstrb; cap_araddr = bus.araddr;
      end
      if (done) begin lat = n; r_load = load_data; r_err = axil_err; break; end
    end
    if (lat > 0) begin
      @(negedge clk); #1;
      r_done_after = done; r_load_after = load_data; r_err_after = axil_err;
    end
  endtask

  function automatic int exp_lat(input mem_op_t op);
    if (op == MEM_SW)
      return ((cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d) + cfg_b_d + 3;
    return cfg_ar_d + cfg_r_d + 3;
  endfunction

  function automatic bit stall_ok(input int lat);
    if (lat < 1) return 1'b0;
    for (int i = 0; i < lat; i++) if (!h_stall[i]) return 1'b0;
    return !h_stall[lat];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; axil_en = 1'b0; mem_op = MEM_NONE; axil_addr = '0; store_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({done, stall, axil_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got done/stall/err=%b expected 000", {done, stall, axil_err}); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load: got %h expected 00000000", load_data); end
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin errors++; $display("FAIL reset_bus: got %b expected 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}); end
    @(negedge clk); rst_n = 1'b1;
    exp_load = '0; exp_err = 1'b0;
  endtask

  task automatic test_ignore_other();
    logic [2:0] bad;
    bad = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      axil_en = 1'b1; mem_op = (i[0]) ? MEM_LBU : MEM_NONE; axil_addr = 32'h2000;
      #1;
      bad = bad | {stall, done, bus.awvalid | bus.arvalid | bus.wvalid};
    end
    @(negedge clk); axil_en = 1'b0; mem_op = MEM_NONE; #1;
    bad = bad | {stall, done, bus.awvalid | bus.arvalid | bus.wvalid};
    checks++; if (bad !== 3'b000) begin errors++; $display("FAIL ignore_other_op: got stall/done/valid=%b expected 000", bad); end
  endtask

  task automatic test_sw_zero_wait();
    int lat, aw0, w0, b0, s0;
    slave_cfg(0, 0, 0, 0, 0);
    aw0 = n_aw; w0 = n_w; b0 = n_b; s0 = n_stab;
    do_txn(MEM_SW, 32'h2404, 32'hA5A5_1234, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_zw_latency: got %0d expected 3", lat); end
    checks++; if (!stall_ok(lat)) begin errors++; $display("FAIL sw_zw_stall: got low before DONE or high at DONE, expected high cycles 0..%0d", lat - 1); end
    checks++; if ({cap_awaddr, cap_wdata, cap_wstrb} !== {32'h2404, 32'hA5A5_1234, 4'hF}) begin errors++; $display("FAIL sw_zw_payload: got %h %h %h expected 00002404 a5a51234 f", cap_awaddr, cap_wdata, cap_wstrb); end
    checks++; if ({n_aw - aw0, n_w - w0, n_b - b0} !== {32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL sw_zw_handshakes: got aw=%0d w=%0d b=%0d expected 1 1 1", n_aw - aw0, n_w - w0, n_b - b0); end
    checks++; if ({r_err, r_load} !== {1'b0, exp_load}) begin errors++; $display("FAIL sw_zw_result: got err=%b load=%h expected 0 %h", r_err, r_load, exp_load); end
    checks++; if ({r_done_after, r_err_after, r_load_after} !== {1'b0, 1'b0, exp_load}) begin errors++; $display("FAIL sw_zw_done_pulse: got done=%b err=%b load=%h expected 0 0 %h", r_done_after, r_err_after, r_load_after, exp_load); end
    checks++; if (n_stab !== s0) begin errors++; $display("FAIL sw_zw_stability: got %0d violations expected 0", n_stab - s0); end
  endtask

  task automatic test_lw_ar_delay();
    int lat, s0;
    slave_cfg(0, 0, 3, 0, 0);
    cfg_rdata = 32'hCAFE_F00D;
    s0 = n_stab;
    do_txn(MEM_LW, 32'h2408, 32'h0, lat);
    exp_load = 32'hCAFE_F00D; exp_err = 1'b0;
    checks++; if (lat !== exp_lat(MEM_LW)) begin errors++; $display("FAIL lw_ar_latency: got %0d expected %0d", lat, exp_lat(MEM_LW)); end
    checks++; if ({h_ar[1], h_ar[2], h_ar[3], h_ar[4], h_ar[5]} !== 5'b11110) begin errors++; $display("FAIL lw_ar_hold: got %b expected 11110", {h_ar[1], h_ar[2], h_ar[3], h_ar[4], h_ar[5]}); end
    checks++; if (cap_araddr !== 32'h2408 || n_stab !== s0) begin errors++; $display("FAIL lw_ar_stable: got araddr=%h violations=%0d expected 00002408 0", cap_araddr, n_stab - s0); end
    checks++; if ({r_err, r_load} !== {exp_err, exp_load}) begin errors++; $display("FAIL lw_ar_result: got err=%b load=%h expected %b %h", r_err, r_load, exp_err, exp_load); end
    checks++; if (r_load_after !== exp_load) begin errors++; $display("FAIL lw_ar_load_hold: got %h expected %h", r_load_after, exp_load); end
  endtask

  task automatic test_sw_w_first();
    int lat, b0, s0;
    slave_cfg(2, 0, 0, 0, 0);
    b0 = n_b; s0 = n_stab;
    do_txn(MEM_SW, 32'h2410, 32'h1357_9BDF, lat);
    checks++; if (lat !== exp_lat(MEM_SW)) begin errors++; $display("FAIL sw_wfirst_latency: got %0d expected %0d", lat, exp_lat(MEM_SW)); end
    checks++; if ({h_w[1], h_w[2], h_w[3]} !== 3'b100) begin errors++; $display("FAIL sw_wfirst_wvalid: got %b expected 100", {h_w[1], h_w[2], h_w[3]}); end
    checks++; if ({h_aw[1], h_aw[2], h_aw[3], h_aw[4]} !== 4'b1110) begin errors++; $display("FAIL sw_wfirst_awvalid: got %b expected 1110", {h_aw[1], h_aw[2], h_aw[3], h_aw[4]}); end
    checks++; if (n_b - b0 !== 1 || n_stab !== s0) begin errors++; $display("FAIL sw_wfirst_bresp: got b=%0d violations=%0d expected 1 0", n_b - b0, n_stab - s0); end
    checks++; if ({r_err, r_load} !== {1'b0, exp_load}) begin errors++; $display("FAIL sw_wfirst_load_kept: got err=%b load=%h expected 0 %h", r_err, r_load, exp_load); end
  endtask

  task automatic test_lw_slverr();
    int lat;
    slave_cfg(0, 0, 1, 2, 1);
    cfg_rresp = 2'b10; cfg_rdata = $urandom;
    do_txn(MEM_LW, 32'h240C, 32'h0, lat);
    exp_load = cfg_rdata; exp_err = 1'b1;
    checks++; if ({r_err, r_load} !== {exp_err, exp_load}) begin errors++; $display("FAIL lw_slverr_result: got err=%b load=%h expected 1 %h", r_err, r_load, exp_load); end
    checks++; if (r_err_after !== 1'b1) begin errors++; $display("FAIL lw_slverr_err_hold: got %b expected 1", r_err_after); end
    slave_cfg(0, 1, 0, 0, 0);
    do_txn(MEM_SW, 32'h2400, 32'h0BAD_F00D, lat);
    exp_err = 1'b0;
    checks++; if ({r_err, r_load} !== {exp_err, exp_load}) begin errors++; $display("FAIL okay_clears_err: got err=%b load=%h expected 0 %h", r_err, r_load, exp_load); end
  endtask

  task automatic test_random();
    int lat, aw0, w0, b0, ar0, r0, s0, el;
    mem_op_t op;
    logic [31:0] a, d;
    for (int it = 0; it < 12; it++) begin
      slave_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata = $urandom;
      op = ($urandom_range(0, 1) == 1) ? MEM_LW : MEM_SW;
      a = $urandom & 32'hFFFF_FFFC; d = $urandom;
      aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; s0 = n_stab;
      el = exp_lat(op);
      do_txn(op, a, d, lat);
      if (op == MEM_LW) begin exp_load = cfg_rdata; exp_err = (cfg_rresp != 2'b00); end
      else exp_err = (cfg_bresp != 2'b00);
      checks++; if (lat !== el || !stall_ok(lat)) begin errors++; $display("FAIL rand%0d_timing: got latency %0d stall_ok=%b expected %0d 1", it, lat, stall_ok(lat), el); end
      checks++; if ({r_err, r_load, r_err_after, r_load_after} !== {exp_err, exp_load, exp_err, exp_load}) begin errors++; $display("FAIL rand%0d_result: got err=%b load=%h expected %b %h", it, r_err, r_load, exp_err, exp_load); end
      if (op == MEM_SW) begin
        checks++; if ({cap_awaddr, cap_wdata, n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0} !== {a, d, 32'd1, 32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL rand%0d_write_bus: got addr=%h data=%h aw=%0d w=%0d b=%0d ar=%0d expected %h %h 1 1 1 0", it, cap_awaddr, cap_wdata, n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0, a, d); end
      end else begin
        checks++; if ({cap_araddr, n_ar - ar0, n_r - r0, n_aw - aw0} !== {a, 32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL rand%0d_read_bus: got addr=%h ar=%0d r=%0d aw=%0d expected %h 1 1 0", it, cap_araddr, n_ar - ar0, n_r - r0, n_aw - aw0, a); end
      end
      checks++; if (n_stab !== s0) begin errors++; $display("FAIL rand%0d_stability: got %0d violations expected 0", it, n_stab - s0); end
    end
  endtask

  task automatic test_timeout();
    int lat;
    slave_cfg(0, 0, 1000, 0, 0);
    do_txn(MEM_LW, 32'h2500, 32'h0, lat);
    exp_load = 32'h0; exp_err = 1'b1;
    checks++; if (lat !== TO + 1 || !stall_ok(lat)) begin errors++; $display("FAIL rd_timeout_timing: got latency %0d expected %0d", lat, TO + 1); end
    checks++; if ({r_err, r_load, h_ar[TO], h_ar[TO + 1]} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL rd_timeout_result: got err=%b load=%h arvalid=%b%b expected 1 00000000 10", r_err, r_load, h_ar[TO], h_ar[TO + 1]); end
    // restore a non-zero load value so the write timeout has something to clear
    slave_cfg(0, 0, 0, 0, 0);
    cfg_rdata = 32'h7777_1111;
    do_txn(MEM_LW, 32'h2504, 32'h0, lat);
    slave_cfg(0, 0, 0, 0, 0);
    cfg_b_never = 1'b1;
    do_txn(MEM_SW, 32'h2508, 32'h5555_AAAA, lat);
    checks++; if (lat !== TO + 1 || !stall_ok(lat)) begin errors++; $display("FAIL wr_timeout_timing: got latency %0d expected %0d", lat, TO + 1); end
    checks++; if ({r_err, r_load} !== {exp_err, exp_load}) begin errors++; $display("FAIL wr_timeout_result: got err=%b load=%h expected 1 00000000", r_err, r_load); end
    checks++; if ({h_b[TO], h_b[TO + 1], r_done_after} !== 3'b100) begin errors++; $display("FAIL wr_timeout_bready: got bready=%b%b done_after=%b expected 10 0", h_b[TO], h_b[TO + 1], r_done_after); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    slave_cfg(0, 0, 0, 0, 0);
    cfg_rdata = 32'h1234_5678;
    do_txn(MEM_LW, 32'h2600, 32'h0, lat);
    checks++; if (load_data !== 32'h1234_5678) begin errors++; $display("FAIL pre_reset_load: got %h expected 12345678", load_data); end
    cfg_r_d = 6; cfg_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    axil_en = 1'b1; mem_op = MEM_LW; axil_addr = 32'h2604;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); axil_en = 1'b0; mem_op = MEM_NONE; #1;
      if (bus.rready) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL reset_mid_reach_rd_resp: got no RREADY within 20 cycles expected RREADY"); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({done, stall, axil_err, load_data} !== {3'b000, 32'h0}) begin errors++; $display("FAIL reset_mid_outputs: got done/stall/err=%b load=%h expected 000 00000000", {done, stall, axil_err}, load_data); end
    checks++; if ({bus.rready, bus.arvalid, bus.awvalid, bus.wvalid, bus.bready, bus.araddr} !== {5'b0, 32'h0}) begin errors++; $display("FAIL reset_mid_bus: got %b araddr=%h expected 00000 00000000", {bus.rready, bus.arvalid, bus.awvalid, bus.wvalid, bus.bready}, bus.araddr); end
    @(negedge clk); rst_n = 1'b1;
    slave_cfg(0, 0, 1, 0, 1);
    cfg_rdata = 32'h0F0F_A5A5;
    do_txn(MEM_LW, 32'h2608, 32'h0, lat);
    checks++; if ({lat, r_err, r_load} !== {exp_lat(MEM_LW), 1'b0, 32'h0F0F_A5A5}) begin errors++; $display("FAIL reset_mid_next_lw: got latency %0d err=%b load=%h expected %0d 0 0f0fa5a5", lat, r_err, r_load, exp_lat(MEM_LW)); end
  endtask

  initial begin
    slave_cfg(0, 0, 0, 0, 0);
    cfg_rdata = '0;
    test_reset();
    test_ignore_other();
    test_sw_zero_wait();
    test_lw_ar_delay();
    test_sw_w_first();
    test_lw_slverr();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
